// File: rtl/hdlc_pkg.sv
// Shared types for the HDLC receive deframer: frame states and per-bit run events.
package hdlc_pkg;

    typedef enum logic [1:0] {
        HUNT,
        FLAG,
        DATA
    } frame_state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_DATA0,
        EV_DATA1,
        EV_STUFF,
        EV_FLAG,
        EV_ABORT
    } run_evt_t;

    // Width of a counter spanning 0..STUFF_RUN+2 ones.
    function automatic int run_cnt_width(input int stuff_run);
        return $clog2(stuff_run + 3);
    endfunction

endpackage

// File: rtl/hdlc_run_detector.sv
// Counts consecutive ones on the qualified serial stream and classifies each bit
// as data, stuffed zero, flag close or abort.
module hdlc_run_detector
    import hdlc_pkg::*;
#(
    parameter int STUFF_RUN = 5
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     in_valid,
    input  logic     in,
    output run_evt_t evt
);

    localparam int CW = run_cnt_width(STUFF_RUN);
    localparam logic [CW-1:0] CNT_STUFF = CW'(STUFF_RUN);
    localparam logic [CW-1:0] CNT_FLAG  = CW'(STUFF_RUN + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STUFF_RUN + 2);

    logic [CW-1:0] ones_cnt_reg;
    logic [CW-1:0] ones_cnt_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ones_cnt_reg <= '0;
        end else begin
            ones_cnt_reg <= ones_cnt_next;
        end
    end

    always_comb begin
        ones_cnt_next = ones_cnt_reg;
        evt           = EV_NONE;
        if (in_valid) begin
            if (in) begin
                // Saturated counter means the abort already fired for this run.
                if (ones_cnt_reg != CNT_MAX) begin
                    ones_cnt_next = ones_cnt_reg + 1'b1;
                    evt           = (ones_cnt_reg == CNT_FLAG) ? EV_ABORT : EV_DATA1;
                end
            end else begin
                ones_cnt_next = '0;
                if (ones_cnt_reg == CNT_STUFF) begin
                    evt = EV_STUFF;
                end else if (ones_cnt_reg == CNT_FLAG) begin
                    evt = EV_FLAG;
                end else begin
                    evt = EV_DATA0;
                end
            end
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: delays bits through a pending line so flag bits can be
// retracted, then packs committed bits LSB-first into words with framing pulses.
module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter int STUFF_RUN = 5,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic              in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_abort,
    output logic              flag_seen,
    output logic              discard
);

    localparam int L  = STUFF_RUN + 2;
    localparam int PW = $clog2(L + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [PW-1:0] PEND_FULL = PW'(L);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

    run_evt_t evt;

    hdlc_run_detector #(
        .STUFF_RUN (STUFF_RUN)
    ) u_run_detector (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in       (in),
        .evt      (evt)
    );

    frame_state_t      state_reg, state_next;
    logic [L-1:0]      pend_reg, pend_next;
    logic [PW-1:0]     pend_cnt_reg, pend_cnt_next;
    logic [DATA_W-1:0] asm_reg, asm_next;
    logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic              first_word_reg, first_word_next;

    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              out_valid_reg, out_valid_next;
    logic              frame_start_reg, frame_start_next;
    logic              frame_end_reg, frame_end_next;
    logic              frame_abort_reg, frame_abort_next;
    logic              flag_seen_reg, flag_seen_next;
    logic              discard_reg, discard_next;

    logic push, push_bit, commit, commit_bit, word_done;

    // A bit only leaves the pending line once L newer bits prove it is not part of a flag.
    assign push       = (state_reg != HUNT) && ((evt == EV_DATA0) || (evt == EV_DATA1));
    assign push_bit   = (evt == EV_DATA1);
    assign commit     = push && (pend_cnt_reg == PEND_FULL);
    assign commit_bit = pend_reg[L-1];
    assign word_done  = commit && (bit_cnt_reg == LAST_BIT);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_asm
            assign asm_next[gi] = (commit && (bit_cnt_reg == BW'(gi))) ? commit_bit : asm_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg       <= HUNT;
            pend_reg        <= '0;
            pend_cnt_reg    <= '0;
            asm_reg         <= '0;
            bit_cnt_reg     <= '0;
            first_word_reg  <= 1'b0;
            out_data_reg    <= '0;
            out_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_end_reg   <= 1'b0;
            frame_abort_reg <= 1'b0;
            flag_seen_reg   <= 1'b0;
            discard_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pend_reg        <= pend_next;
            pend_cnt_reg    <= pend_cnt_next;
            asm_reg         <= asm_next;
            bit_cnt_reg     <= bit_cnt_next;
            first_word_reg  <= first_word_next;
            out_data_reg    <= out_data_next;
            out_valid_reg   <= out_valid_next;
            frame_start_reg <= frame_start_next;
            frame_end_reg   <= frame_end_next;
            frame_abort_reg <= frame_abort_next;
            flag_seen_reg   <= flag_seen_next;
            discard_reg     <= discard_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pend_next        = pend_reg;
        pend_cnt_next    = pend_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        first_word_next  = first_word_reg;
        out_data_next    = out_data_reg;
        out_valid_next   = 1'b0;
        frame_start_next = 1'b0;
        frame_end_next   = 1'b0;
        frame_abort_next = 1'b0;
        flag_seen_next   = 1'b0;
        discard_next     = 1'b0;

        if (push) begin
            pend_next = {pend_reg[L-2:0], push_bit};
            if (!commit) begin
                pend_cnt_next = pend_cnt_reg + 1'b1;
            end
        end

        if (commit) begin
            if (state_reg == FLAG) begin
                state_next      = DATA;
                first_word_next = 1'b1;
            end
            if (word_done) begin
                out_valid_next   = 1'b1;
                out_data_next    = asm_next;
                frame_start_next = first_word_reg || (state_reg == FLAG);
                first_word_next  = 1'b0;
                bit_cnt_next     = '0;
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end

        case (evt)
            EV_STUFF: begin
                discard_next = (state_reg != HUNT);
            end
            EV_FLAG: begin
                flag_seen_next  = 1'b1;
                pend_cnt_next   = '0;
                bit_cnt_next    = '0;
                first_word_next = 1'b0;
                state_next      = FLAG;
                // A zero bit count inside DATA means at least one whole word was emitted.
                if (state_reg == DATA) begin
                    if (bit_cnt_reg == '0) begin
                        frame_end_next = 1'b1;
                    end else begin
                        frame_abort_next = 1'b1;
                    end
                end
            end
            EV_ABORT: begin
                frame_abort_next = (state_reg != HUNT);
                pend_cnt_next    = '0;
                bit_cnt_next     = '0;
                first_word_next  = 1'b0;
                state_next       = HUNT;
            end
            default: begin
            end
        endcase
    end

    assign out_data    = out_data_reg;
    assign out_valid   = out_valid_reg;
    assign frame_start = frame_start_reg;
    assign frame_end   = frame_end_reg;
    assign frame_abort = frame_abort_reg;
    assign flag_seen   = flag_seen_reg;
    assign discard     = discard_reg;

endmodule

// File: doc/hdlc_rx_deframer.md
# hdlc_rx_deframer

Parametrised successor to the one-hot bit-stuffing FSM: a clocked HDLC-style receive deframer with a valid qualifier and a serial input, one bit per qualified cycle. Detects stuffed zeros, flags and aborts for a configurable run length. Removes flag bits from the data path and assembles the remaining bits LSB-first into DATA_W-bit words. Framing pulses go to the downstream frame buffer. Sits directly after the line-side bit sampler.

## Interface
- STUFF_RUN, default 5: ones before a stuffed zero; legal range 2..14.
- DATA_W, default 8: output word width; legal range 1..32.
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  qualifies in; cycles with in_valid=0 change no state.
- in  in  1  serial line bit.
- out_data  out  DATA_W  assembled word, LSB = first received bit; held between words.
- out_valid  out  1  one-cycle pulse, out_data valid.
- frame_start  out  1  pulses with the first out_valid of a frame.
- frame_end  out  1  pulse, closing flag on a word-aligned frame.
- frame_abort  out  1  pulse, abort sequence or misaligned closing flag.
- flag_seen  out  1  pulse, any flag detected.
- discard  out  1  pulse, stuffed zero dropped.

## Operation
- **Flag and abort definitions**
  - Run length L = STUFF_RUN+2.
  - Flag = 0, STUFF_RUN+1 ones, 0.
  - Abort = L consecutive ones.
- **Run counter**: ones_cnt, 0..L, saturating; updated only on in_valid.
- **Classification when in=0 with in_valid=1**
  - ones_cnt==STUFF_RUN: stuff event.
  - ones_cnt==STUFF_RUN+1: flag event.
  - Otherwise: data zero.
  - In all three cases ones_cnt is then cleared.
- **in=1**: ones_cnt increments. Reaching L is an abort event, fired once per run. Further ones fire nothing until a zero is received.
- **Pending line**: shift register of depth L holding non-stuffed, non-flag-closing bits.
  - A push into the full line evicts the oldest bit, and that bit is committed to the assembler.
  - A flag flushes the pending line; the flag's opening 0 and ones never reach data.
  - The closing 0 of a flag is never pushed. Shared-zero back-to-back flags are legal.
- **Frame states** (hdlc_pkg enum):
  - HUNT: reset state. Bits are not pushed; no stuff or data processing. Flag event → FLAG.
  - FLAG: between frames. The first committed bit → DATA. A flag event stays in FLAG and produces flag_seen only, no frame pulse (empty frame).
  - DATA: a flag event → FLAG with frame_end if committed bit count mod DATA_W == 0; otherwise frame_abort and the partial word is dropped.
  - Abort event in FLAG or DATA: frame_abort pulse, pending and assembler cleared, → HUNT.
  - Abort event in HUNT: no pulse.
- **discard**: pulses on a stuff event in FLAG or DATA only.
- **Assembler**: fills from bit 0 upward. When DATA_W bits are filled it raises out_valid and restarts. Its bit counter is cleared on every flag or abort.
- **Reset values**: all outputs 0; out_data = 0; ones_cnt = 0; pending empty; state HUNT.

## Timing
- All outputs are registered. Every pulse asserts in the cycle after the qualifying in_valid cycle and lasts exactly one cycle.
- Bit-to-word latency: out_valid follows, by one cycle, the in_valid cycle that commits bit DATA_W-1. That bit is committed when it is evicted, L pushes after it entered.
- The final word of a frame is committed by the last one of the closing flag, so its out_valid strictly precedes frame_end.
- A flag and an abort never coincide. out_valid never coincides with flag_seen, frame_end or frame_abort.
- resetn low overrides everything, including mid-frame. No pulses are emitted in the cycle after reset release.
- in_valid gaps of any length are transparent to the result.

## Structure
- hdlc_pkg holds:
  - the frame_state_t enum {HUNT, FLAG, DATA};
  - the run_evt_t enum {EV_NONE, EV_DATA0, EV_DATA1, EV_STUFF, EV_FLAG, EV_ABORT}.
- Sub-module hdlc_run_detector contains ones_cnt and the classification logic and emits run_evt_t per valid bit.
- The top level contains the pending line, the assembler, the frame FSM and the output registers.

## Test plan
All sequences below are sent with in_valid=1 unless noted.
1. **Reset**: hold resetn=0 for 3 cycles, then send 1,0,1,0 → all outputs 0 and no pulses (state HUNT).
2. **Aligned frame**: flag, then 0x5A LSB-first (0,1,0,1,1,0,1,0), then flag → flag_seen ×2; out_valid+frame_start with out_data=0x5A; frame_end one cycle after the closing 0.
3. **Stuffed byte**: flag, then 1,1,1,1,1,0,1,1,1, then flag → one discard pulse and out_data=0xFF.
4. **Abort**: flag, 4 data bits, then 7 ones → frame_abort one cycle after the 7th one, no out_valid; 3 more ones give no pulse; a following flag gives flag_seen only.
5. **Misaligned frame**: flag, 12 data bits, flag → one out_valid, then frame_abort, with no frame_end.
6. **Back-to-back flags**: 0,1,1,1,1,1,1,0,1,1,1,1,1,1,0 with random in_valid gaps → two flag_seen pulses, no out_valid or frame pulses.
